// File: rtl/dnn_pkg.sv
// dnn_pkg: shared constants, binary16 field positions and helpers for the classifier layers.
// Also holds the fc2_argmax state encoding.
package dnn_pkg;
   localparam int NUM_CLASSES = 10;
   localparam int FP_W        = 16;
   localparam int FP_SIGN     = 15;
   localparam int FP_EXP_HI   = 14;
   localparam int FP_EXP_LO   = 10;
   localparam int FP_MANT_HI  = 9;
   localparam int FP_MANT_LO  = 0;
   localparam logic [FP_EXP_HI-FP_EXP_LO:0] FP16_NAN_EXP = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic fp16_is_nan(input logic [FP_W-1:0] x);
      return (x[FP_EXP_HI:FP_EXP_LO] == FP16_NAN_EXP) && (|x[FP_MANT_HI:FP_MANT_LO]);
   endfunction

   // Maps binary16 onto an unsigned key whose integer order is the float order; both zeros share one key.
   function automatic logic [FP_W-1:0] fp16_key(input logic [FP_W-1:0] x);
      logic [FP_W-1:0] w_mag;
      w_mag = {1'b0, x[FP_SIGN-1:0]};
      if (w_mag == '0)
         return {1'b1, {(FP_W-1){1'b0}}};
      return x[FP_SIGN] ? ~x : (x | {1'b1, {(FP_W-1){1'b0}}});
   endfunction
endpackage

// File: rtl/float16_gt.sv
// float16_gt: combinational strict a > b on binary16; +0 equals -0, any NaN operand yields 0.
module float16_gt
   import dnn_pkg::*;
(
   input  logic [FP_W-1:0] i_a,
   input  logic [FP_W-1:0] i_b,
   output logic            o_gt
);
   logic w_nan;

   assign w_nan = fp16_is_nan(i_a) || fp16_is_nan(i_b);
   assign o_gt  = !w_nan && (fp16_key(i_a) > fp16_key(i_b));
endmodule

// File: rtl/fc2_argmax.sv
// fc2_argmax: latches the FC2 scores, scans them one per cycle and reports the index and value
// of the largest score, a one-hot LED vector and an error flag (FC2 overflow or NaN seen).
module fc2_argmax
   import dnn_pkg::*;
(
   input  logic                        clk,
   input  logic                        iRst_n,
   input  logic                        ena,
   input  logic [NUM_CLASSES*FP_W-1:0] scores,
   input  logic                        overflow_in,
   output logic                        done,
   output logic [3:0]                  digit,
   output logic [NUM_CLASSES-1:0]      digit_onehot,
   output logic [FP_W-1:0]             max_score,
   output logic                        error
);
   state_t                              r_state;
   state_t                              w_next;
   logic [NUM_CLASSES-1:0][FP_W-1:0]    r_scores;
   logic [3:0]                          r_idx;
   logic [3:0]                          r_best_idx;
   logic [FP_W-1:0]                     r_best;
   logic [FP_W-1:0]                     w_elem;
   logic                                w_gt;
   logic                                w_last;

   assign w_elem = r_scores[r_idx];
   assign w_last = (r_idx == 4'(NUM_CLASSES-1));

   float16_gt u_gt (
      .i_a  (w_elem),
      .i_b  (r_best),
      .o_gt (w_gt)
   );

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (!ena)
         w_next = ST_IDLE;
      else if (r_state == ST_IDLE)
         w_next = ST_LOAD;
      else if (r_state == ST_LOAD)
         w_next = ST_SCAN;
      else if (r_state == ST_SCAN)
         w_next = w_last ? ST_DONE : ST_SCAN;
   end

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_scores     <= '0;
         r_idx        <= '0;
         r_best_idx   <= '0;
         r_best       <= '0;
         done         <= 1'b0;
         digit        <= '0;
         digit_onehot <= '0;
         max_score    <= '0;
         error        <= 1'b0;
      end else if (!ena || r_state == ST_IDLE) begin
         done         <= 1'b0;
         digit        <= '0;
         digit_onehot <= '0;
         max_score    <= '0;
         error        <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_scores   <= scores;
               error      <= overflow_in;
               r_idx      <= '0;
               r_best_idx <= '0;
               r_best     <= '0;
            end
            ST_SCAN: begin
               // NaN elements are skipped; the comparator already rejects them, this only flags them.
               if (fp16_is_nan(w_elem))
                  error <= 1'b1;
               else if (w_gt) begin
                  r_best     <= w_elem;
                  r_best_idx <= r_idx;
               end
               r_idx <= r_idx + 4'd1;
            end
            ST_DONE: begin
               done         <= 1'b1;
               digit        <= r_best_idx;
               digit_onehot <= NUM_CLASSES'(1) << r_best_idx;
               max_score    <= r_best;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fc2_argmax.sv
// tb_fc2_argmax: directed vectors; expected results are queued at issue and a monitor checks them when done rises.
module tb_fc2_argmax;
   import dnn_pkg::*;

   typedef struct {
      logic [3:0]  digit;
      logic [15:0] max;
      logic        err;
   } exp_t;

   logic                        clk = 0;
   logic                        iRst_n = 0;
   logic                        ena = 0;
   logic [9:0][15:0]            scores = '0;
   logic                        overflow_in = 0;
   logic                        done;
   logic [3:0]                  digit;
   logic [9:0]                  digit_onehot;
   logic [15:0]                 max_score;
   logic                        error;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   logic prev_done = 0;

   fc2_argmax dut (
      .clk          (clk),
      .iRst_n       (iRst_n),
      .ena          (ena),
      .scores       (scores),
      .overflow_in  (overflow_in),
      .done         (done),
      .digit        (digit),
      .digit_onehot (digit_onehot),
      .max_score    (max_score),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (done && !prev_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no result pending");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("digit", 32'(digit), 32'(e.digit));
            chk("onehot", 32'(digit_onehot), 32'(10'd1 << e.digit));
            chk("max_score", 32'(max_score), 32'(e.max));
            chk("error", 32'(error), 32'(e.err));
         end
      end
      prev_done = done;
   end

   task automatic check_cleared(input string tag);
      chk({tag, "_done0"}, 32'(done), 0);
      chk({tag, "_digit0"}, 32'(digit), 0);
      chk({tag, "_onehot0"}, 32'(digit_onehot), 0);
      chk({tag, "_max0"}, 32'(max_score), 0);
      chk({tag, "_err0"}, 32'(error), 0);
   endtask

   // Issues a vector; scores/overflow are scrambled right after LOAD to prove they were registered.
   task automatic run(input logic [9:0][15:0] sc, input logic ovf, input logic [3:0] d,
                      input logic [15:0] m, input logic e, input bit do_rst);
      int c;
      exp_t x;
      x.digit = d; x.max = m; x.err = e;
      @(negedge clk);
      scores = sc; overflow_in = ovf; ena = 1;
      q.push_back(x);
      if (do_rst) begin
         repeat (7) @(posedge clk);
         @(negedge clk);
         chk("err_latched_in_scan", 32'(error), 32'(ovf));
         iRst_n = 0;
         #1;
         check_cleared("async_rst");
         @(negedge clk);
         iRst_n = 1;
      end
      c = 0;
      while (!done && c < 40) begin
         @(posedge clk);
         #1;
         c++;
         if (c == 2) begin
            scores = '1;
            overflow_in = !ovf;
         end
      end
      chk("latency_edges", 32'(c), 13);
      @(negedge clk);
      ena = 0;
      scores = '0;
      overflow_in = 0;
      @(posedge clk);
      #1;
      check_cleared("ena_drop");
   endtask

   initial begin
      logic [9:0][15:0] sc;
      #1;
      check_cleared("reset");
      repeat (2) @(negedge clk);
      iRst_n = 1;

      sc = '0; sc[3] = 16'h3C00;
      run(sc, 0, 4'd3, 16'h3C00, 0, 0);

      sc = '0; sc[2] = 16'h4000; sc[7] = 16'h4000;
      run(sc, 0, 4'd2, 16'h4000, 0, 0);

      sc = {10{16'h8000}}; sc[9] = 16'h0000;
      run(sc, 0, 4'd0, 16'h0000, 0, 0);

      sc = '0; sc[5] = 16'h7E00; sc[6] = 16'h3800;
      run(sc, 1, 4'd6, 16'h3800, 1, 0);

      sc = '0; sc[1] = 16'h7BFF; sc[4] = 16'h7C00; sc[8] = 16'hFC00; sc[0] = 16'hBC00;
      run(sc, 0, 4'd4, 16'h7C00, 0, 0);

      sc = '0; sc[0] = 16'h0001; sc[1] = 16'h03FF; sc[2] = 16'h0400; sc[3] = 16'h03FE;
      run(sc, 0, 4'd2, 16'h0400, 0, 0);

      sc = {10{16'h7E00}}; sc[3] = 16'hFE00; sc[7] = 16'h7C01;
      run(sc, 0, 4'd0, 16'h0000, 1, 0);

      sc = '0; sc[8] = 16'h5000; sc[1] = 16'h4FFF;
      run(sc, 1, 4'd8, 16'h5000, 1, 1);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
